// File: rtl/store_handler_multi_pkg.sv
// Shared encodings for the store handler: command modes, response status codes, FSM states.
package store_pkg;

    localparam logic [1:0] MODE_RESTOCK = 2'b00;
    localparam logic [1:0] MODE_BUY     = 2'b01;
    localparam logic [1:0] MODE_PRICE   = 2'b10;
    localparam logic [1:0] MODE_QUERY   = 2'b11;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_NO_STOCK  = 3'd1;
    localparam logic [2:0] ST_NO_CREDIT = 3'd2;
    localparam logic [2:0] ST_BAD_CODE  = 3'd3;
    localparam logic [2:0] ST_OVERFLOW  = 3'd4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_LOAD = 2'd1;
    localparam state_t S_EXEC = 2'd2;
    localparam state_t S_RESP = 2'd3;

endpackage

// File: rtl/store_handler_multi_if.sv
// Command/response bus of the store handler. rspSold exists only when STORE_SALES_STATS_EN is defined.
interface store_handler_multi_if #(
    parameter int unsigned NUM_PRODUCTS = 8,
    parameter int unsigned COUNT_W      = 4,
    parameter int unsigned PRICE_W      = 4,
    parameter int unsigned CREDIT_W     = 8
) ();
    localparam int unsigned CODE_W = $clog2(NUM_PRODUCTS);

    logic                cmdValid;
    logic                cmdReady;
    logic [1:0]          mode;
    logic [CODE_W-1:0]   productCode;
    logic [COUNT_W-1:0]  itemCount;
    logic [PRICE_W-1:0]  newPrice;
    logic [CREDIT_W-1:0] credit;

    logic                rspValid;
    logic [2:0]          rspStatus;
    logic [COUNT_W-1:0]  rspStock;
    logic [PRICE_W-1:0]  rspPrice;
    logic [CREDIT_W-1:0] rspCost;
    logic [CREDIT_W-1:0] rspChange;
`ifdef STORE_SALES_STATS_EN
    logic [COUNT_W+3:0]  rspSold;
`endif

    modport master (
        output cmdValid, mode, productCode, itemCount, newPrice, credit,
        input  cmdReady, rspValid, rspStatus, rspStock, rspPrice, rspCost, rspChange
`ifdef STORE_SALES_STATS_EN
        , input rspSold
`endif
    );

    modport slave (
        input  cmdValid, mode, productCode, itemCount, newPrice, credit,
        output cmdReady, rspValid, rspStatus, rspStock, rspPrice, rspCost, rspChange
`ifdef STORE_SALES_STATS_EN
        , output rspSold
`endif
    );

endinterface

// File: rtl/store_handler_multi_table.sv
// Per-slot stock/price register file: one registered read port, one write port with split enables.
module store_table #(
    parameter int unsigned NUM_PRODUCTS = 8,
    parameter int unsigned COUNT_W      = 4,
    parameter int unsigned PRICE_W      = 4,
    parameter int unsigned INIT_PRICE   = 1,
    parameter int unsigned CODE_W       = $clog2(NUM_PRODUCTS)
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic [CODE_W-1:0]  rdAddr,
    output logic [COUNT_W-1:0] rdStock,
    output logic [PRICE_W-1:0] rdPrice,
    input  logic [CODE_W-1:0]  wrAddr,
    input  logic               wrStockEn,
    input  logic [COUNT_W-1:0] wrStock,
    input  logic               wrPriceEn,
    input  logic [PRICE_W-1:0] wrPrice
);
    logic [COUNT_W-1:0] stockMem [NUM_PRODUCTS];
    logic [PRICE_W-1:0] priceMem [NUM_PRODUCTS];
    logic               rdInRange;

    // Unpopulated codes read as zero instead of indexing past the array.
    assign rdInRange = ({1'b0, rdAddr} < (CODE_W+1)'(NUM_PRODUCTS));

    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < int'(NUM_PRODUCTS); i++) begin
                stockMem[i] <= '0;
                priceMem[i] <= PRICE_W'(INIT_PRICE);
            end
            rdStock <= '0;
            rdPrice <= '0;
        end else begin
            if (wrStockEn) stockMem[wrAddr] <= wrStock;
            if (wrPriceEn) priceMem[wrAddr] <= wrPrice;
            rdStock <= rdInRange ? stockMem[rdAddr] : '0;
            rdPrice <= rdInRange ? priceMem[rdAddr] : '0;
        end
    end

endmodule

// File: rtl/store_handler_multi.sv
// Store handler: command FSM (IDLE->LOAD->EXEC->RESP) with credit/overflow checks over store_table.
// Optional per-slot sales counters and rspSold output under `define STORE_SALES_STATS_EN.
module store_handler_multi
    import store_pkg::*;
#(
    parameter int unsigned NUM_PRODUCTS = 8,
    parameter int unsigned COUNT_W      = 4,
    parameter int unsigned PRICE_W      = 4,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned INIT_PRICE   = 1
) (
    input  logic                 clock,
    input  logic                 resetN,
    store_handler_multi_if.slave bus
);
    localparam int unsigned CODE_W = $clog2(NUM_PRODUCTS);
    localparam int unsigned PC_W   = PRICE_W + COUNT_W;

    state_t              state, stateNext;
    logic [1:0]          latMode;
    logic [CODE_W-1:0]   latCode;
    logic [COUNT_W-1:0]  latCount;
    logic [PRICE_W-1:0]  latPrice;
    logic [CREDIT_W-1:0] latCredit;
    logic [COUNT_W-1:0]  rdStock;
    logic [PRICE_W-1:0]  rdPrice;

    logic                badCode_c;
    logic [PC_W-1:0]     cost_c;
    logic [CREDIT_W-1:0] costExt_c;
    logic [COUNT_W:0]    restockSum_c;
    logic [2:0]          status_c;
    logic [COUNT_W-1:0]  stockOut_c;
    logic [PRICE_W-1:0]  priceOut_c;
    logic [CREDIT_W-1:0] rspCost_c;
    logic [CREDIT_W-1:0] rspChange_c;
    logic [COUNT_W-1:0]  wrStock_c;
    logic                wrStockEn_c;
    logic                wrPriceEn_c;
    logic                buyOk_c;

    store_table #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .COUNT_W      (COUNT_W),
        .PRICE_W      (PRICE_W),
        .INIT_PRICE   (INIT_PRICE),
        .CODE_W       (CODE_W)
    ) u_table (
        .clock     (clock),
        .resetN    (resetN),
        .rdAddr    (latCode),
        .rdStock   (rdStock),
        .rdPrice   (rdPrice),
        .wrAddr    (latCode),
        .wrStockEn (wrStockEn_c),
        .wrStock   (wrStock_c),
        .wrPriceEn (wrPriceEn_c),
        .wrPrice   (latPrice)
    );

    // State, command latch and registered response.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state         <= S_IDLE;
            bus.cmdReady  <= 1'b1;
            bus.rspValid  <= 1'b0;
            bus.rspStatus <= '0;
            bus.rspStock  <= '0;
            bus.rspPrice  <= '0;
            bus.rspCost   <= '0;
            bus.rspChange <= '0;
            latMode       <= '0;
            latCode       <= '0;
            latCount      <= '0;
            latPrice      <= '0;
            latCredit     <= '0;
        end else begin
            state        <= stateNext;
            bus.cmdReady <= (stateNext == S_IDLE);
            bus.rspValid <= (state == S_RESP);
            if (bus.cmdValid && bus.cmdReady) begin
                latMode   <= bus.mode;
                latCode   <= bus.productCode;
                latCount  <= bus.itemCount;
                latPrice  <= bus.newPrice;
                latCredit <= bus.credit;
            end
            if (state == S_EXEC) begin
                bus.rspStatus <= status_c;
                bus.rspStock  <= stockOut_c;
                bus.rspPrice  <= priceOut_c;
                bus.rspCost   <= rspCost_c;
                bus.rspChange <= rspChange_c;
            end
        end
    end

    // Next state plus command evaluation; table writes only fire in EXEC.
    always_comb begin
        stateNext   = state;
        status_c    = ST_OK;
        stockOut_c  = rdStock;
        priceOut_c  = rdPrice;
        rspCost_c   = '0;
        rspChange_c = '0;
        wrStock_c   = rdStock;
        wrStockEn_c = 1'b0;
        wrPriceEn_c = 1'b0;
        buyOk_c     = 1'b0;

        case (state)
            S_IDLE:  if (bus.cmdValid && bus.cmdReady) stateNext = S_LOAD;
            S_LOAD:  stateNext = S_EXEC;
            S_EXEC:  stateNext = S_RESP;
            S_RESP:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase

        badCode_c    = ({1'b0, latCode} >= (CODE_W+1)'(NUM_PRODUCTS));
        cost_c       = PC_W'(rdPrice) * PC_W'(latCount);
        costExt_c    = CREDIT_W'(cost_c);
        restockSum_c = (COUNT_W+1)'(rdStock) + (COUNT_W+1)'(latCount);

        if (badCode_c) begin
            status_c   = ST_BAD_CODE;
            stockOut_c = '0;
            priceOut_c = '0;
            if (latMode == MODE_BUY) rspChange_c = latCredit;
        end else begin
            case (latMode)
                MODE_RESTOCK: begin
                    if (restockSum_c[COUNT_W]) begin
                        status_c = ST_OVERFLOW;
                    end else begin
                        wrStock_c   = restockSum_c[COUNT_W-1:0];
                        wrStockEn_c = 1'b1;
                        stockOut_c  = restockSum_c[COUNT_W-1:0];
                    end
                end
                MODE_BUY: begin
                    rspCost_c   = costExt_c;
                    rspChange_c = latCredit;
                    if (rdStock < latCount) begin
                        status_c = ST_NO_STOCK;
                    end else if (costExt_c > latCredit) begin
                        status_c = ST_NO_CREDIT;
                    end else begin
                        buyOk_c     = 1'b1;
                        wrStock_c   = rdStock - latCount;
                        wrStockEn_c = 1'b1;
                        stockOut_c  = rdStock - latCount;
                        rspChange_c = latCredit - costExt_c;
                    end
                end
                MODE_PRICE: begin
                    wrPriceEn_c = 1'b1;
                    priceOut_c  = latPrice;
                end
                default: ;
            endcase
        end

        if (state != S_EXEC) begin
            wrStockEn_c = 1'b0;
            wrPriceEn_c = 1'b0;
            buyOk_c     = 1'b0;
        end
    end

`ifdef STORE_SALES_STATS_EN
    localparam int unsigned SOLD_W = COUNT_W + 4;

    logic [SOLD_W-1:0] soldMem [NUM_PRODUCTS];
    logic [SOLD_W-1:0] soldCur_c;
    logic [SOLD_W-1:0] soldNext_c;
    logic [SOLD_W:0]   soldSum_c;

    // Saturating per-slot sales count.
    always_comb begin
        soldCur_c = '0;
        if (!badCode_c) soldCur_c = soldMem[latCode];
        soldSum_c  = (SOLD_W+1)'(soldCur_c) + (SOLD_W+1)'(latCount);
        soldNext_c = soldSum_c[SOLD_W] ? '1 : soldSum_c[SOLD_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < int'(NUM_PRODUCTS); i++) soldMem[i] <= '0;
            bus.rspSold <= '0;
        end else begin
            if (buyOk_c) soldMem[latCode] <= soldNext_c;
            if (state == S_EXEC) bus.rspSold <= buyOk_c ? soldNext_c : soldCur_c;
        end
    end
`endif

endmodule

// File: doc/store_handler_multi.md
Name: store_handler_multi

Overview:
- Parametrised next-generation store handler for the vending machine datapath.
- Holds per-product stock and price tables for NUM_PRODUCTS products.
- Executes restock, buy, set-price and query commands through a valid/ready command handshake.
- Returns a status, stock, price, cost and change response. Buy is credit-checked; restock is overflow-checked.
- Sits between the coin/credit front end and the dispense/display logic.

Parameters:
NUM_PRODUCTS, 8, number of product slots (2..256)
COUNT_W, 4, stock and item-count width; max stock is 2^COUNT_W-1
PRICE_W, 4, unit price width
CREDIT_W, 8, credit/cost/change width; must be >= PRICE_W+COUNT_W
INIT_PRICE, 1, price loaded into every slot at reset
CODE_W, clog2(NUM_PRODUCTS), product code width (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
resetN  in  1  synchronous active-low reset
cmdValid  in  1  command present
cmdReady  out  1  block can accept a command
mode  in  2  00 restock, 01 buy, 10 set price, 11 query
productCode  in  CODE_W  product slot
itemCount  in  COUNT_W  restock quantity / buy quantity
newPrice  in  PRICE_W  price for set-price
credit  in  CREDIT_W  money available for buy
rspValid  out  1  one-cycle response strobe
rspStatus  out  3  0 OK, 1 NO_STOCK, 2 NO_CREDIT, 3 BAD_CODE, 4 OVERFLOW
rspStock  out  COUNT_W  slot stock after the command
rspPrice  out  PRICE_W  slot price after the command
rspCost  out  CREDIT_W  price*itemCount (buy only, else 0)
rspChange  out  CREDIT_W  credit-cost on buy OK, credit on buy failure, else 0

Behaviour:
- Single clock. Reset is synchronous and active-low: resetN is sampled on the rising edge of clock.
- Reset state:
  - FSM in IDLE; cmdReady=1; rspValid=0.
  - All rsp* outputs 0.
  - All stock entries 0; all price entries INIT_PRICE.
- FSM states: IDLE -> LOAD -> EXEC -> RESP -> IDLE.
  - IDLE: cmdReady=1. A command is accepted on an edge where cmdValid && cmdReady; all command inputs are latched on that edge. Move to LOAD.
  - LOAD: read the stock/price entry for the latched code; compute cost = price*itemCount at full PRICE_W+COUNT_W width, zero-extended to CREDIT_W.
  - EXEC: evaluate the command and commit table writes on the exit edge.
  - RESP: rspValid=1 for exactly one cycle; rsp* registers are valid in that cycle. Return to IDLE.
- Latency: command accepted at edge N; rspValid high in the cycle following edge N+3. cmdReady is low in LOAD, EXEC and RESP, so maximum throughput is one command per 4 cycles.
- Error check priority: BAD_CODE, then the mode-specific check. Any error commits nothing.
- BAD_CODE: productCode >= NUM_PRODUCTS; no table access; rspStock=0, rspPrice=0.
- Restock: if stock+itemCount > 2^COUNT_W-1, status OVERFLOW and stock unchanged; otherwise stock += itemCount.
- Buy:
  - stock < itemCount -> NO_STOCK.
  - else cost > credit -> NO_CREDIT.
  - else OK: stock -= itemCount, rspChange = credit-cost.
  - itemCount=0 -> OK, cost 0, change = credit, no change to stock.
- Set price: price = newPrice, always OK; newPrice=0 is legal (free item).
- Query: no writes; status OK.
- Commands arriving while cmdReady=0 are ignored; cmdValid held high is accepted on the next IDLE cycle.
- Reset mid-command: the command is aborted, no commit, no rspValid.

Optional Feature:
STORE_SALES_STATS_EN
- Defined:
  - Adds a per-slot soldCount register of COUNT_W+4 bits, reset to 0.
  - Incremented by itemCount on every buy OK, saturating at its maximum.
  - Adds output port rspSold (COUNT_W+4), carrying the slot's sold count after the command; 0 on BAD_CODE.
- Undefined: no counters and no rspSold port.
- All other behaviour is identical in both builds.

Decomposition:
- Package store_pkg: mode encodings (MODE_RESTOCK/BUY/PRICE/QUERY), status encodings (ST_OK..ST_OVERFLOW), FSM state enum.
- Sub-module store_table: NUM_PRODUCTS-entry register file for stock and price.
  - One read port, read-data registered.
  - One write port with separate stock and price write enables.
  - Reset initialises entries as specified.
- FSM and arithmetic stay in the top module.

Test Plan (defaults: NUM_PRODUCTS=8, COUNT_W=4, PRICE_W=4, CREDIT_W=8, INIT_PRICE=1):
- After reset, restock code 0 count 10 -> rspStatus OK, rspStock 10, rspPrice 1, rspValid 4 cycles after accept; cmdReady low for 3 cycles.
- Set price code 0 to 15, then buy 5 with credit 100 -> price step OK, rspPrice 15; buy OK, rspCost 75, rspChange 25, rspStock 5.
- Buy 6 of code 0 (stock 5) with credit 255 -> NO_STOCK, stock stays 5, rspChange 255; then buy 2 with credit 20 -> NO_CREDIT (cost 30), stock stays 5, rspChange 20.
- Restock code 3 with 15, then restock 1 -> first OK with stock 15; second OVERFLOW with stock 15; query code 3 -> OK, stock 15.
- With NUM_PRODUCTS=5, any command on code 6 -> BAD_CODE, rspStock 0, rspPrice 0; a later query of codes 0..4 shows no table change.
- Assert resetN low during EXEC of a buy on code 0 -> no rspValid, stock 0, price 1 afterwards. With STORE_SALES_STATS_EN defined, two buy-OK commands of 3 on one slot -> rspSold 6.
